// File: rtl/ofmap_accumulator_if.sv
// Psum ingress and finished-ofmap egress channels of one array column.
// master drives psums and accepts results; slave is the accumulator.
interface ofmap_accumulator_if #(
    parameter int OFMAP_WIDTH = 8,
    parameter int ACC_WIDTH   = 16
);
    logic                   psum_valid;
    logic                   psum_ready;
    logic [OFMAP_WIDTH-1:0] psum_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_data;

    modport master (
        output psum_valid,
        output psum_in,
        input  psum_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  psum_valid,
        input  psum_in,
        output psum_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/ofmap_accumulator.sv
// Accumulates column partial sums over input-channel passes into a small
// register bank, then drains the finished ofmap entries downstream.
module ofmap_accumulator #(
    parameter int OFMAP_WIDTH = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int DEPTH       = 4,
    parameter int PASS_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    ofmap_accumulator_if.slave    bus,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [PASS_WIDTH-1:0] passes;
    logic [ACC_WIDTH-1:0]  entry [DEPTH];
    logic [ACC_WIDTH-1:0]  psum_ext;
    logic                  accept;
    logic                  pop;
    logic                  last_wr;
    logic                  last_rd;
    logic                  last_pass;

    assign psum_ext  = ACC_WIDTH'(bus.psum_in);
    assign accept    = (state == ACCUM) && bus.psum_valid;
    assign pop       = (state == DRAIN) && bus.out_ready;
    assign last_wr   = (wr_idx == LAST_IDX);
    assign last_rd   = (rd_idx == LAST_IDX);
    assign last_pass = (pass_cnt == passes - PASS_WIDTH'(1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ACCUM;
            ACCUM:   if (accept && last_wr && last_pass) state_nx = DRAIN;
            DRAIN:   if (pop && last_rd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.psum_ready = (state == ACCUM);
        bus.out_valid  = (state == DRAIN);
        bus.out_data   = '0;
        if (state == DRAIN) bus.out_data = entry[rd_idx];
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            pass_cnt <= '0;
            passes   <= '0;
            done     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else begin
            if (state == IDLE && start) begin
                passes   <= (num_passes == '0) ? PASS_WIDTH'(1) : num_passes;
                wr_idx   <= '0;
                pass_cnt <= '0;
            end
            // first pass overwrites, so no clear cycle is needed between tiles
            if (accept) begin
                entry[wr_idx] <= (pass_cnt == '0) ? psum_ext
                                                  : entry[wr_idx] + psum_ext;
                wr_idx <= last_wr ? '0 : wr_idx + IW'(1);
                if (last_wr) pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                if (last_wr && last_pass) rd_idx <= '0;
            end
            if (pop) rd_idx <= last_rd ? '0 : rd_idx + IW'(1);
            done <= pop && last_rd;
        end
    end
endmodule

// File: doc/ofmap_accumulator.md
Name: ofmap_accumulator

Overview:
Downstream stage of one systolic-array column: consumes partial sums leaving the bottom MAC's ofmap_out and accumulates them across multiple input-channel passes into a small register bank. When the final pass completes, it drains the finished output-feature-map values through a valid/ready interface to the output buffer. A controller sequences each tile with a single start pulse.

Parameters:
OFMAP_WIDTH, 8, width of incoming partial sums (matches MAC ofmap width)
ACC_WIDTH, 16, width of accumulator entries and out_data; must be >= OFMAP_WIDTH
DEPTH, 4, number of ofmap entries per tile (>= 2); index width = clog2(DEPTH)
PASS_WIDTH, 4, width of num_passes

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a tile; honoured only in IDLE
num_passes  input  PASS_WIDTH  passes per tile, latched on start; 0 is treated as 1
psum_valid  input  1  partial sum present on psum_in
psum_in  input  OFMAP_WIDTH  partial sum from array column, unsigned
psum_ready  output  1  block accepts psum this cycle (combinational from state)
out_valid  output  1  out_data holds a finished entry
out_ready  input  1  downstream accepts out_data
out_data  output  ACC_WIDTH  finished accumulated value
busy  output  1  high in ACCUM or DRAIN
done  output  1  one-cycle pulse after the last entry drains

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wr_idx, rd_idx, pass_cnt, latched passes, all entries = 0; psum_ready=0, out_valid=0, out_data=0, busy=0, done=0. Reset asserted mid-tile discards the tile; no done pulse.
- States: IDLE, ACCUM, DRAIN.
- IDLE: psum_ready=0, out_valid=0. psum_valid ignored. On start: latch max(num_passes,1), wr_idx=0, pass_cnt=0, go ACCUM next cycle.
- ACCUM: psum_ready=1. Accept = psum_valid && psum_ready.
  - Pass 0: entry[wr_idx] <= zero-extended psum_in (overwrite; no separate clear cycle needed).
  - Later passes: entry[wr_idx] <= entry[wr_idx] + zero-extended psum_in, truncated modulo 2^ACC_WIDTH (wrap, no saturation).
  - wr_idx increments per accept; at DEPTH-1 wraps to 0 and pass_cnt increments.
  - Accept at wr_idx=DEPTH-1 with pass_cnt = passes-1: go DRAIN next cycle, rd_idx=0. Written value visible at DRAIN entry (1-cycle latency from last accept).
  - Cycles without psum_valid hold all state; bubbles allowed anywhere.
- DRAIN: psum_ready=0 (psum_valid ignored); out_valid=1; out_data=entry[rd_idx].
  - out_data stable while out_valid && !out_ready.
  - Handshake out_valid && out_ready: rd_idx increments; on rd_idx=DEPTH-1 go IDLE, done=1 for exactly the next cycle.
- start ignored in ACCUM and DRAIN; start coincident with done-cycle (IDLE) is honoured.
- busy = (state != IDLE). out_data=0 when not in DRAIN.
- Entries retain values in IDLE until overwritten by next tile's pass 0.

Test Plan:
- Basic 2-pass: DEPTH=4, num_passes=2, psums 1,2,3,4 then 10,20,30,40, out_ready=1 -> out_data 11,22,33,44 on consecutive cycles, done pulse one cycle after 44, busy falls with done.
- Backpressure/bubbles: same tile, psum_valid toggled 1,0,1,0..., out_ready low 3 cycles at entry 1 -> no psum lost; out_data holds 22 while stalled; sequence 11,22,33,44 unchanged.
- Zero/one passes: num_passes=0, psums 5,6,7,8 -> outputs 5,6,7,8 (treated as 1 pass); second tile immediately after with num_passes=1, psums 1,1,1,1 -> 1,1,1,1 (no residue from prior tile).
- Wrap: ACC_WIDTH=8, OFMAP_WIDTH=8, num_passes=2, psums 200,0,0,0 then 100,0,0,0 -> entry0 = 44 (300 mod 256).
- Ignored inputs: psum_valid=1 psum_in=99 while IDLE and during DRAIN, start pulsed during ACCUM -> no entry change, psum_ready=0 outside ACCUM, tile results unaffected.
- Reset mid-tile: rst_n low after 6 accepts of a 2-pass tile -> outputs immediately 0, state IDLE, no done; new tile psums 2,2,2,2 with num_passes=1 -> outputs 2,2,2,2.
